// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: read-allocate, write-through refill controller that sits
// between a single client, a cache with registered read data, and backing memory.
// Ports: clk/rst_n (async active-low); req_* client request with valid/ready;
// rsp_* one-cycle response pulse with held data/hit; c_* cache read/write port;
// mem_* backing-memory request/grant and read-data return.
// Optional: define CACHE_REFILL_CTRL_STATS_EN to add stat_clr, hit_cnt, miss_cnt.
// Every output is a flop whose next value is decoded from the next state.
module cache_refill_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_hit,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  c_re,
    output logic                  c_we,
    output logic [ADDR_WIDTH-1:0] c_read_addr,
    output logic [ADDR_WIDTH-1:0] c_write_addr,
    output logic [DATA_WIDTH-1:0] c_in,
    input  logic [DATA_WIDTH-1:0] c_out,
    input  logic                  c_hit,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef CACHE_REFILL_CTRL_STATS_EN
    ,
    input  logic                  stat_clr,
    output logic [15:0]           hit_cnt,
    output logic [15:0]           miss_cnt
`endif
);

    typedef enum logic [3:0] {
        IDLE,
        LOOKUP,
        CHECK,
        MEM_REQ,
        MEM_WAIT,
        FILL,
        WR_MEM,
        WR_CACHE,
        RESP
    } state_e;

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  hit_q, hit_d;

    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_hit_q, rsp_hit_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  c_re_q, c_re_d;
    logic                  c_we_q, c_we_d;
    logic [ADDR_WIDTH-1:0] c_read_addr_q, c_read_addr_d;
    logic [ADDR_WIDTH-1:0] c_write_addr_q, c_write_addr_d;
    logic [DATA_WIDTH-1:0] c_in_q, c_in_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    // Next state and captured request/response data.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        hit_d   = hit_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    // Cleared so a write responds with zero data, no hit.
                    rdata_d = '0;
                    hit_d   = 1'b0;
                    state_d = req_we ? WR_MEM : LOOKUP;
                end
            end
            LOOKUP: state_d = CHECK;
            CHECK: begin
                if (c_hit) begin
                    rdata_d = c_out;
                    hit_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = MEM_REQ;
                end
            end
            MEM_REQ: begin
                if (mem_gnt) begin
                    if (mem_rvalid) begin
                        rdata_d = mem_rdata;
                        state_d = FILL;
                    end else begin
                        state_d = MEM_WAIT;
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_rvalid) begin
                    rdata_d = mem_rdata;
                    state_d = FILL;
                end
            end
            FILL: begin
                hit_d   = 1'b0;
                state_d = RESP;
            end
            WR_MEM: begin
                if (mem_gnt) begin
                    state_d = WR_CACHE;
                end
            end
            WR_CACHE: state_d = RESP;
            RESP:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear, registered,
    // in the same cycle the FSM occupies that state.
    always_comb begin
        req_ready_d    = (state_d == IDLE);
        rsp_valid_d    = (state_d == RESP);
        rsp_rdata_d    = rsp_rdata_q;
        rsp_hit_d      = rsp_hit_q;
        if (state_d == RESP) begin
            rsp_rdata_d = rdata_d;
            rsp_hit_d   = hit_d;
        end
        c_re_d         = (state_d == LOOKUP);
        c_read_addr_d  = c_re_d ? addr_d : c_read_addr_q;
        c_we_d         = (state_d == FILL) || (state_d == WR_CACHE);
        c_write_addr_d = c_we_d ? addr_d : c_write_addr_q;
        c_in_d         = c_in_q;
        if (state_d == FILL) begin
            c_in_d = rdata_d;
        end else if (state_d == WR_CACHE) begin
            c_in_d = wdata_d;
        end
        mem_req_d      = (state_d == MEM_REQ) || (state_d == WR_MEM);
        mem_we_d       = (state_d == WR_MEM);
        mem_addr_d     = mem_req_d ? addr_d : mem_addr_q;
        mem_wdata_d    = mem_we_d ? wdata_d : mem_wdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            rdata_q        <= '0;
            hit_q          <= 1'b0;
            req_ready_q    <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_hit_q      <= 1'b0;
            rsp_rdata_q    <= '0;
            c_re_q         <= 1'b0;
            c_we_q         <= 1'b0;
            c_read_addr_q  <= '0;
            c_write_addr_q <= '0;
            c_in_q         <= '0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
        end else begin
            state_q        <= state_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            rdata_q        <= rdata_d;
            hit_q          <= hit_d;
            req_ready_q    <= req_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_hit_q      <= rsp_hit_d;
            rsp_rdata_q    <= rsp_rdata_d;
            c_re_q         <= c_re_d;
            c_we_q         <= c_we_d;
            c_read_addr_q  <= c_read_addr_d;
            c_write_addr_q <= c_write_addr_d;
            c_in_q         <= c_in_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_hit      = rsp_hit_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign c_re         = c_re_q;
    assign c_we         = c_we_q;
    assign c_read_addr  = c_read_addr_q;
    assign c_write_addr = c_write_addr_q;
    assign c_in         = c_in_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;

`ifdef CACHE_REFILL_CTRL_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    // Clear takes priority; counters stick at all-ones.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (stat_clr) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end else if (state_q == CHECK) begin
            if (c_hit) begin
                if (hit_cnt_q != 16'hFFFF) begin
                    hit_cnt_d = hit_cnt_q + 16'd1;
                end
            end else if (miss_cnt_q != 16'hFFFF) begin
                miss_cnt_d = miss_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: directed self-checking bench for cache_refill_ctrl.
// Each task drives one scenario and checks outputs #1 after rising edges.
module tb_cache_refill_ctrl;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_hit;
    logic [7:0] rsp_rdata;
    logic       c_re;
    logic       c_we;
    logic [7:0] c_read_addr;
    logic [7:0] c_write_addr;
    logic [7:0] c_in;
    logic [7:0] c_out;
    logic       c_hit;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_gnt;
    logic       mem_rvalid;
    logic [7:0] mem_rdata;
`ifdef CACHE_REFILL_CTRL_STATS_EN
    logic        stat_clr;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int rsp_cnt = 0;
    int mem_req_cnt = 0;
    int c_we_cnt = 0;
    int conflict_cnt = 0;

    cache_refill_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_rdata(rsp_rdata),
        .c_re(c_re), .c_we(c_we), .c_read_addr(c_read_addr),
        .c_write_addr(c_write_addr), .c_in(c_in), .c_out(c_out), .c_hit(c_hit),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
`ifdef CACHE_REFILL_CTRL_STATS_EN
        , .stat_clr(stat_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rsp_valid) rsp_cnt++;
        if (mem_req) mem_req_cnt++;
        if (c_we) c_we_cnt++;
        if (c_re && c_we) conflict_cnt++;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl got rdy=%b rv=%b mreq=%b exp 0 0 0",
                     req_ready, rsp_valid, mem_req);
        end
        checks++;
        if ({c_re, c_we, rsp_rdata, c_in, mem_addr} !== 26'd0) begin
            errors++;
            $display("FAIL reset_data got re=%b we=%b rd=%h cin=%h ma=%h exp 0",
                     c_re, c_we, rsp_rdata, c_in, mem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got=%b exp=1", req_ready);
        end
    endtask

    task automatic test_read_hit(input logic [7:0] a, input logic [7:0] d);
        int mr0 = mem_req_cnt;
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        c_hit = 1'b1; c_out = d;
        // Stray read data outside the memory states must be ignored.
        mem_rvalid = 1'b1; mem_rdata = 8'h3C;
        step();
        req_valid = 1'b0;
        checks++;
        if (c_re !== 1'b1 || c_read_addr !== a || c_we !== 1'b0) begin
            errors++;
            $display("FAIL hit_lookup got re=%b ra=%h we=%b exp 1 %h 0",
                     c_re, c_read_addr, c_we, a);
        end
        step();
        checks++;
        if (c_re !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL hit_check got re=%b rv=%b exp 0 0", c_re, rsp_valid);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== d || rsp_hit !== 1'b1) begin
            errors++;
            $display("FAIL hit_resp got rv=%b rd=%h hit=%b exp 1 %h 1",
                     rsp_valid, rsp_rdata, rsp_hit, d);
        end
        step();
        c_hit = 1'b0; mem_rvalid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_req_cnt != mr0) begin
            errors++;
            $display("FAIL hit_end got rv=%b rdy=%b mreq_cycles=%0d exp 0 1 0",
                     rsp_valid, req_ready, mem_req_cnt - mr0);
        end
    endtask

    // gd: MEM_REQ cycles before grant; rd: idle MEM_WAIT cycles, <0 = with grant
    task automatic test_read_miss(input logic [7:0] a, input int gd,
                                  input int rd, input logic [7:0] d);
        int cw0 = c_we_cnt;
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        c_hit = 1'b0; c_out = 8'hEE;
        step();
        req_valid = 1'b0;
        step();
        step();
        for (int i = 0; i <= gd; i++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== a) begin
                errors++;
                $display("FAIL miss_memreq cyc=%0d got req=%b we=%b a=%h exp 1 0 %h",
                         i, mem_req, mem_we, mem_addr, a);
            end
            if (i < gd) step();
        end
        mem_gnt = 1'b1;
        if (rd < 0) begin
            mem_rvalid = 1'b1; mem_rdata = d;
        end
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        if (rd >= 0) begin
            checks++;
            if (mem_req !== 1'b0 || c_we !== 1'b0) begin
                errors++;
                $display("FAIL miss_wait got req=%b cwe=%b exp 0 0", mem_req, c_we);
            end
            for (int i = 0; i < rd; i++) step();
            mem_rvalid = 1'b1; mem_rdata = d;
            step();
            mem_rvalid = 1'b0; mem_rdata = 8'h00;
        end
        checks++;
        if (c_we !== 1'b1 || c_write_addr !== a || c_in !== d || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL miss_fill got we=%b wa=%h in=%h rv=%b exp 1 %h %h 0",
                     c_we, c_write_addr, c_in, rsp_valid, a, d);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== d || rsp_hit !== 1'b0) begin
            errors++;
            $display("FAIL miss_resp got rv=%b rd=%h hit=%b exp 1 %h 0",
                     rsp_valid, rsp_rdata, rsp_hit, d);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== d
            || c_we_cnt - cw0 != 1) begin
            errors++;
            $display("FAIL miss_end got rv=%b rdy=%b rd=%h cwe=%0d exp 0 1 %h 1",
                     rsp_valid, req_ready, rsp_rdata, c_we_cnt - cw0, d);
        end
    endtask

    task automatic test_write;
        int cw0 = c_we_cnt;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h40; req_wdata = 8'h77;
        step();
        req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h40
                || mem_wdata !== 8'h77 || c_we !== 1'b0) begin
                errors++;
                $display("FAIL wr_mem cyc=%0d got req=%b we=%b a=%h d=%h exp 1 1 40 77",
                         i, mem_req, mem_we, mem_addr, mem_wdata);
            end
            if (i < 4) step();
        end
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        checks++;
        if (c_we !== 1'b1 || c_write_addr !== 8'h40 || c_in !== 8'h77
            || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL wr_cache got we=%b wa=%h in=%h mreq=%b exp 1 40 77 0",
                     c_we, c_write_addr, c_in, mem_req);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h00 || rsp_hit !== 1'b0) begin
            errors++;
            $display("FAIL wr_resp got rv=%b rd=%h hit=%b exp 1 00 0",
                     rsp_valid, rsp_rdata, rsp_hit);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || c_we_cnt - cw0 != 1) begin
            errors++;
            $display("FAIL wr_end got rv=%b rdy=%b cwe=%0d exp 0 1 1",
                     rsp_valid, req_ready, c_we_cnt - cw0);
        end
    endtask

    task automatic test_reset_mid;
        int r0 = rsp_cnt;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h21; c_hit = 1'b0;
        step();
        req_valid = 1'b0;
        step();
        step();
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || req_ready !== 1'b0 || c_we !== 1'b0) begin
            errors++;
            $display("FAIL rstwait got mreq=%b rdy=%b cwe=%b exp 0 0 0",
                     mem_req, req_ready, c_we);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 8'hAB;
        step();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstwait_ready got=%b exp=1", req_ready);
        end
        step();
        mem_rvalid = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h50; req_wdata = 8'h0F;
        step();
        req_valid = 1'b0; req_we = 1'b0;
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rstwr_pre got mreq=%b exp=1", mem_req);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_wdata !== 8'h00) begin
            errors++;
            $display("FAIL rstwr_drop got mreq=%b mwe=%b wd=%h exp 0 0 00",
                     mem_req, mem_we, mem_wdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (rsp_cnt != r0 || req_ready !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_noresp got rsps=%0d rdy=%b mreq=%b exp 0 1 0",
                     rsp_cnt - r0, req_ready, mem_req);
        end
    endtask

`ifdef CACHE_REFILL_CTRL_STATS_EN
    task automatic test_stats;
        test_read_hit(8'h01, 8'h11);
        test_read_miss(8'h02, 0, 0, 8'h22);
        test_read_hit(8'h03, 8'h33);
        test_read_miss(8'h04, 1, -1, 8'h44);
        test_read_hit(8'h05, 8'h55);
        checks++;
        if (hit_cnt !== 16'd3 || miss_cnt !== 16'd2) begin
            errors++;
            $display("FAIL stats_cnt got hit=%0d miss=%0d exp 3 2", hit_cnt, miss_cnt);
        end
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        checks++;
        if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
            errors++;
            $display("FAIL stats_clr got hit=%0d miss=%0d exp 0 0", hit_cnt, miss_cnt);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        c_out = '0; c_hit = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
`ifdef CACHE_REFILL_CTRL_STATS_EN
        stat_clr = 1'b0;
`endif
        test_reset();
        test_read_hit(8'h12, 8'hA5);
        test_read_miss(8'h34, 2, 2, 8'h5C);
        test_write();
        test_read_miss(8'h56, 0, -1, 8'h99);
        test_reset_mid();
`ifdef CACHE_REFILL_CTRL_STATS_EN
        test_stats();
`endif
        checks++;
        if (conflict_cnt != 0) begin
            errors++;
            $display("FAIL re_we_overlap got=%0d cycles exp=0", conflict_cnt);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, which sets the data word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, which sets the address width.
REQ-003 SHALL have ports, one per line:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- req_valid  in  1  client request present
- req_ready  out  1  controller accepts request
- req_we  in  1  1=write, 0=read
- req_addr  in  ADDR_WIDTH  client address
- req_wdata  in  DATA_WIDTH  client write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_hit  out  1  read was served from the cache
- rsp_rdata  out  DATA_WIDTH  read data
- c_re  out  1  cache read enable
- c_we  out  1  cache write enable
- c_read_addr  out  ADDR_WIDTH  cache read address
- c_write_addr  out  ADDR_WIDTH  cache write address
- c_in  out  DATA_WIDTH  cache write data
- c_out  in  DATA_WIDTH  registered cache read data
- c_hit  in  1  registered cache hit
- mem_req  out  1  backing-memory request
- mem_we  out  1  memory write
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_gnt  in  1  memory accepted the request
- mem_rvalid  in  1  memory read data valid
- mem_rdata  in  DATA_WIDTH  memory read data

Function
REQ-004 SHALL implement an FSM with states IDLE, LOOKUP, CHECK, MEM_REQ, MEM_WAIT, FILL, WR_MEM, WR_CACHE and RESP.
REQ-005 SHALL drive req_ready=1 only in IDLE, and SHALL capture we, addr and wdata into registers on a req_valid&&req_ready cycle.
REQ-006 SHALL move from IDLE to LOOKUP on an accepted read and to WR_MEM on an accepted write.
REQ-007 LOOKUP SHALL assert c_re=1 with c_read_addr=captured addr for exactly one cycle, then go to CHECK.
REQ-008 CHECK SHALL sample c_hit/c_out: on a hit, latch the data and rsp_hit=1 and go to RESP; on a miss, go to MEM_REQ.
REQ-009 MEM_REQ SHALL hold mem_req=1, mem_we=0 and a stable mem_addr until mem_gnt=1.
REQ-010 If mem_gnt and mem_rvalid are both 1 in MEM_REQ, the controller SHALL latch mem_rdata and go to FILL; on mem_gnt alone it SHALL go to MEM_WAIT.
REQ-011 MEM_WAIT SHALL wait for mem_rvalid, latch mem_rdata, then go to FILL.
REQ-012 FILL SHALL assert c_we=1 for one cycle with c_write_addr=addr and c_in=the refilled data, set rsp_hit=0, then go to RESP.
REQ-013 WR_MEM SHALL hold mem_req=1, mem_we=1, mem_addr and mem_wdata stable until mem_gnt, then go to WR_CACHE (write-through).
REQ-014 WR_CACHE SHALL assert c_we=1 for one cycle with the captured addr/wdata, then go to RESP.
REQ-015 RESP SHALL assert rsp_valid=1 for exactly one cycle, then return to IDLE.
REQ-016 For writes, rsp_rdata SHALL be 0 and rsp_hit SHALL be 0.
REQ-017 Read hit latency SHALL be: accept at cycle N, rsp_valid at cycle N+3.
REQ-018 Read miss latency SHALL be N+3+memory wait cycles+1.
REQ-019 mem_rvalid SHALL be ignored outside MEM_REQ and MEM_WAIT.
REQ-020 c_re and c_we SHALL never be asserted in the same cycle.
REQ-021 All outputs SHALL be registered, and rsp_rdata/rsp_hit SHALL hold their value until the next RESP.

Reset
REQ-022 While rst_n=0, the state SHALL be IDLE, req_ready=0, and every other output and captured register SHALL be 0, applied immediately without waiting for a clock.
REQ-023 Reset mid-transaction SHALL drop mem_req at once, and no response SHALL be issued for the aborted request.
REQ-024 On the first clk edge after rst_n rises, req_ready SHALL be 1.

Configuration
REQ-025 With macro CACHE_REFILL_CTRL_STATS_EN defined, the block SHALL add the following:
- input stat_clr (1 bit)
- outputs hit_cnt[15:0] and miss_cnt[15:0], incremented in CHECK on read hit/miss, saturating at 16'hFFFF, cleared synchronously by stat_clr (clear wins over increment), reset to 0
REQ-026 Without CACHE_REFILL_CTRL_STATS_EN, these ports and counters SHALL be absent, and the remaining behaviour SHALL be identical.

Verification
REQ-027 The bench SHALL cover these scenarios:
- Reset, then read 0x12 with c_hit=1, c_out=0xA5 -> rsp_valid at accept+3, rsp_rdata=0xA5, rsp_hit=1, mem_req never asserted.
- Read 0x34 with c_hit=0, mem_gnt after 2 cycles, mem_rvalid 3 cycles later with 0x5C -> one c_we with c_write_addr=0x34, c_in=0x5C; then rsp_rdata=0x5C, rsp_hit=0.
- Write 0x40 with data 0x77, mem_gnt delayed 4 cycles -> mem_we=1 with mem_wdata=0x77 held stable; after gnt, one c_we with 0x40/0x77; rsp_valid with rsp_rdata=0.
- Miss with mem_gnt and mem_rvalid in the same cycle (0x99) -> goes straight to FILL; response 0x99.
- rst_n low while in MEM_WAIT -> mem_req=0 immediately; no rsp_valid; after reset, req_ready=1.
- STATS_EN: 3 hits and 2 misses -> hit_cnt=3, miss_cnt=2; pulse stat_clr -> both counters 0.
